uart_time_reporter: RTL and testbench

UART_TIME_REPORTER -- requirements
Module: uart_time_reporter

---
 rtl/uart_pkg.sv | 25 ++
 rtl/bin_to_ascii2.sv | 24 ++
 rtl/uart_time_reporter.sv | 128 ++++++++++++
 tb/tb_uart_time_reporter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM encoding, ASCII constants and frame geometry for the time reporter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitBusy,
    StWaitDone
  } state_e;

  localparam logic [7:0] AsciiZero  = 8'h30;
  localparam logic [7:0] AsciiColon = 8'h3A;
  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;

  // Frame lengths with and without the trailing CR LF.
  localparam int unsigned FrameLenCrlf = 10;
  localparam int unsigned FrameLenBare = 8;

  // Largest legal field values; anything above is sent as these.
  localparam logic [4:0] HourMax   = 5'd23;
  localparam logic [5:0] MinSecMax = 6'd59;

endpackage

// File: rtl/bin_to_ascii2.sv
// Combinational binary (0-99) to two ASCII decimal digits, tens first.
module bin_to_ascii2
  import uart_pkg::*;
(
  input  logic [6:0] value,
  output logic [7:0] tens_char,
  output logic [7:0] ones_char
);

  logic [3:0] tens;
  logic [3:0] ones;

  // Find the tens digit by threshold compare, remainder gives the ones digit.
  always_comb begin
    tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (value >= 7'(i * 10)) tens = 4'(i);
    end
    ones      = 4'(value - 7'(tens) * 7'd10);
    tens_char = AsciiZero + {4'h0, tens};
    ones_char = AsciiZero + {4'h0, ones};
  end

endmodule

// File: rtl/uart_time_reporter.sv
// Sends "HH:MM:SS" (optionally followed by CR LF) to a byte UART on request.
module uart_time_reporter
  import uart_pkg::*;
#(
  parameter int unsigned EOL_CRLF      = 1,
  parameter int unsigned BUSY_WAIT_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       report_req,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       report_busy,
  output logic       report_done
);

  localparam logic [3:0] LastIdx = (EOL_CRLF != 0) ? 4'(FrameLenCrlf - 1) : 4'(FrameLenBare - 1);
  // Counter only needs to reach BUSY_WAIT_MAX-1.
  localparam int unsigned CntW = (BUSY_WAIT_MAX < 2) ? 1 : $clog2(BUSY_WAIT_MAX);

  state_e          state;
  logic [3:0]      idx;
  logic [CntW-1:0] wait_cnt;
  logic [4:0]      snap_hour;
  logic [5:0]      snap_min;
  logic [5:0]      snap_sec;

  logic [7:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o;
  logic [3:0] send_idx;
  logic [7:0] send_byte;
  logic       wait_expired;
  logic       byte_finished;

  bin_to_ascii2 u_hour (.value({2'b00, snap_hour}), .tens_char(hour_t), .ones_char(hour_o));
  bin_to_ascii2 u_min  (.value({1'b0, snap_min}),   .tens_char(min_t),  .ones_char(min_o));
  bin_to_ascii2 u_sec  (.value({1'b0, snap_sec}),   .tens_char(sec_t),  .ones_char(sec_o));

  // Select the byte that the next SEND will present: index 0 from LOAD, else idx+1.
  always_comb begin
    send_idx = (state == StLoad) ? 4'd0 : idx + 4'd1;
    unique case (send_idx)
      4'd0:    send_byte = hour_t;
      4'd1:    send_byte = hour_o;
      4'd2:    send_byte = AsciiColon;
      4'd3:    send_byte = min_t;
      4'd4:    send_byte = min_o;
      4'd5:    send_byte = AsciiColon;
      4'd6:    send_byte = sec_t;
      4'd7:    send_byte = sec_o;
      4'd8:    send_byte = AsciiCr;
      4'd9:    send_byte = AsciiLf;
      default: send_byte = 8'h00;
    endcase
  end

  // A byte is done when the UART drops busy, or never raised it within the wait budget.
  always_comb begin
    wait_expired  = (32'(wait_cnt) + 32'd1) >= BUSY_WAIT_MAX;
    byte_finished = !tx_busy && ((state == StWaitDone) ||
                                 (state == StWaitBusy && wait_expired));
  end

  // Frame sequencer with registered UART and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      report_busy <= 1'b0;
      report_done <= 1'b0;
      idx         <= 4'd0;
      wait_cnt    <= '0;
      snap_hour   <= 5'd0;
      snap_min    <= 6'd0;
      snap_sec    <= 6'd0;
    end else begin
      tx_start    <= 1'b0;
      report_done <= 1'b0;
      unique case (state)
        StIdle: begin
          // A request landing on the done pulse is dropped, not deferred.
          if (report_req && !report_done) begin
            snap_hour   <= (hour > HourMax) ? HourMax : hour;
            snap_min    <= (min > MinSecMax) ? MinSecMax : min;
            snap_sec    <= (sec > MinSecMax) ? MinSecMax : sec;
            idx         <= 4'd0;
            report_busy <= 1'b1;
            state       <= StLoad;
          end
        end
        StLoad: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= send_byte;
            state    <= StSend;
          end
        end
        StSend: begin
          wait_cnt <= '0;
          state    <= StWaitBusy;
        end
        StWaitBusy, StWaitDone: begin
          if (byte_finished) begin
            if (idx == LastIdx) begin
              report_busy <= 1'b0;
              report_done <= 1'b1;
              state       <= StIdle;
            end else begin
              idx      <= idx + 4'd1;
              tx_start <= 1'b1;
              tx_data  <= send_byte;
              state    <= StSend;
            end
          end else if (state == StWaitBusy) begin
            if (tx_busy) state <= StWaitDone;
            else wait_cnt <= wait_cnt + CntW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Scoreboard bench: two reporters (with and without CR LF) and simple UART busy models.
module tb_uart_time_reporter;

  localparam int BusyWaitMax = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;

  logic       req_a, busy_a, start_a, rbusy_a, done_a;
  logic [7:0] data_a;
  logic       req_b, busy_b, start_b, rbusy_b, done_b;
  logic [7:0] data_b;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int starts_a = 0;
  int starts_b = 0;
  int last_start_a = 0;
  bit spacing_en = 1'b0;

  bit busy_mode_a = 1'b0;
  bit busy_mode_b = 1'b0;
  int busy_cnt_a = 0;
  int busy_cnt_b = 0;

  always #5 clk = ~clk;

  uart_time_reporter #(.EOL_CRLF(1), .BUSY_WAIT_MAX(BusyWaitMax)) dut_a (
    .clk(clk), .rst(rst), .report_req(req_a), .hour(hour), .min(min), .sec(sec),
    .tx_busy(busy_a), .tx_data(data_a), .tx_start(start_a),
    .report_busy(rbusy_a), .report_done(done_a)
  );

  uart_time_reporter #(.EOL_CRLF(0), .BUSY_WAIT_MAX(BusyWaitMax)) dut_b (
    .clk(clk), .rst(rst), .report_req(req_b), .hour(hour), .min(min), .sec(sec),
    .tx_busy(busy_b), .tx_data(data_b), .tx_start(start_b),
    .report_busy(rbusy_b), .report_done(done_b)
  );

  always @(posedge clk) cycle <= cycle + 1;

  // UART models: busy for 10 cycles starting the cycle after tx_start, or tied low.
  always @(posedge clk) begin
    if (!busy_mode_a) busy_cnt_a <= 0;
    else if (start_a) busy_cnt_a <= 10;
    else if (busy_cnt_a != 0) busy_cnt_a <= busy_cnt_a - 1;
    if (!busy_mode_b) busy_cnt_b <= 0;
    else if (start_b) busy_cnt_b <= 10;
    else if (busy_cnt_b != 0) busy_cnt_b <= busy_cnt_b - 1;
  end
  assign busy_a = (busy_cnt_a != 0);
  assign busy_b = (busy_cnt_b != 0);

  // Scoreboard: every tx_start pops and compares one expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (start_a) begin
      tests++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL byte_a: unexpected tx_start data %h, expected no byte", data_a);
      end else begin
        e = exp_a.pop_front();
        if (data_a !== e) begin
          fails++;
          $display("FAIL byte_a[%0d]: got %h expected %h", starts_a, data_a, e);
        end
      end
      if (spacing_en && starts_a > 0) begin
        tests++;
        if (cycle - last_start_a != BusyWaitMax + 1) begin
          fails++;
          $display("FAIL spacing_a: got %0d cycles expected %0d",
                   cycle - last_start_a, BusyWaitMax + 1);
        end
      end
      last_start_a = cycle;
      starts_a++;
    end
    if (start_b) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL byte_b: unexpected tx_start data %h, expected no byte", data_b);
      end else begin
        e = exp_b.pop_front();
        if (data_b !== e) begin
          fails++;
          $display("FAIL byte_b[%0d]: got %h expected %h", starts_b, data_b, e);
        end
      end
      starts_b++;
    end
  end

  task automatic push_a(input logic [7:0] b[10]);
    for (int i = 0; i < 10; i++) exp_a.push_back(b[i]);
  endtask

  task automatic pulse_req_a();
    @(negedge clk); req_a = 1'b1;
    @(negedge clk); req_a = 1'b0;
  endtask

  // Returns with the clock just past the edge that raised report_done.
  task automatic wait_done(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if ((which ? done_b : done_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout_%s: got no report_done expected one within 1000 cycles",
               which ? "b" : "a");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    hour = 5'd0; min = 6'd0; sec = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    tests += 8;
    if (data_a !== 8'h00) begin fails++; $display("FAIL rst_data_a: got %h expected 00", data_a); end
    if (start_a !== 1'b0) begin fails++; $display("FAIL rst_start_a: got %b expected 0", start_a); end
    if (rbusy_a !== 1'b0) begin fails++; $display("FAIL rst_busy_a: got %b expected 0", rbusy_a); end
    if (done_a !== 1'b0)  begin fails++; $display("FAIL rst_done_a: got %b expected 0", done_a); end
    if (data_b !== 8'h00) begin fails++; $display("FAIL rst_data_b: got %h expected 00", data_b); end
    if (start_b !== 1'b0) begin fails++; $display("FAIL rst_start_b: got %b expected 0", start_b); end
    if (rbusy_b !== 1'b0) begin fails++; $display("FAIL rst_busy_b: got %b expected 0", rbusy_b); end
    if (done_b !== 1'b0)  begin fails++; $display("FAIL rst_done_b: got %b expected 0", done_b); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] f[10] = '{8'h31, 8'h33, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h30, 8'h39, 8'h0D, 8'h0A};
    bit ok;
    busy_mode_a = 1'b1; starts_a = 0;
    hour = 5'd13; min = 6'd5; sec = 6'd9;
    push_a(f);
    @(negedge clk); req_a = 1'b1;
    @(posedge clk); #1;
    tests += 2;
    if (rbusy_a !== 1'b1) begin fails++; $display("FAIL accept_busy: got %b expected 1", rbusy_a); end
    if (start_a !== 1'b0) begin fails++; $display("FAIL early_start: got %b expected 0", start_a); end
    @(negedge clk); req_a = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (start_a !== 1'b1) begin fails++; $display("FAIL latency: tx_start got %b expected 1", start_a); end
    wait_done(1'b0, ok);
    tests += 3;
    if (starts_a != 10) begin fails++; $display("FAIL basic_count: got %0d expected 10", starts_a); end
    if (rbusy_a !== 1'b0) begin fails++; $display("FAIL basic_busy_end: got %b expected 0", rbusy_a); end
    if (exp_a.size() != 0) begin
      fails++; $display("FAIL basic_left: got %0d pending expected 0", exp_a.size());
    end
    @(posedge clk); #1;
    tests++;
    if (done_a !== 1'b0) begin fails++; $display("FAIL done_pulse: got %b expected 0", done_a); end
  endtask

  task automatic test_no_crlf();
    bit ok;
    busy_mode_b = 1'b1; starts_b = 0;
    hour = 5'd0; min = 6'd0; sec = 6'd0;
    exp_b = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30};
    @(negedge clk); req_b = 1'b1;
    @(negedge clk); req_b = 1'b0;
    wait_done(1'b1, ok);
    tests += 3;
    if (starts_b != 8) begin fails++; $display("FAIL bare_count: got %0d expected 8", starts_b); end
    if (exp_b.size() != 0) begin
      fails++; $display("FAIL bare_left: got %0d pending expected 0", exp_b.size());
    end
    if (rbusy_b !== 1'b0) begin fails++; $display("FAIL bare_busy_end: got %b expected 0", rbusy_b); end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_clamp();
    logic [7:0] f[10] = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};
    bit ok;
    busy_mode_a = 1'b1; starts_a = 0;
    hour = 5'd31; min = 6'd63; sec = 6'd60;
    push_a(f);
    pulse_req_a();
    wait_done(1'b0, ok);
    tests++;
    if (starts_a != 10) begin fails++; $display("FAIL clamp_count: got %0d expected 10", starts_a); end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_ignore();
    logic [7:0] f[10] = '{8'h30, 8'h37, 8'h3A, 8'h34, 8'h32, 8'h3A, 8'h33, 8'h30, 8'h0D, 8'h0A};
    bit ok;
    busy_mode_a = 1'b0; starts_a = 0; spacing_en = 1'b1;
    hour = 5'd7; min = 6'd42; sec = 6'd30;
    push_a(f);
    pulse_req_a();
    for (int i = 0; i < 200 && starts_a < 3; i++) @(posedge clk);
    hour = 5'd22; min = 6'd11; sec = 6'd1;
    pulse_req_a();
    wait_done(1'b0, ok);
    spacing_en = 1'b0;
    tests += 2;
    if (starts_a != 10) begin fails++; $display("FAIL ignore_count: got %0d expected 10", starts_a); end
    if (exp_a.size() != 0) begin
      fails++; $display("FAIL ignore_left: got %0d pending expected 0", exp_a.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f[10] = '{8'h32, 8'h32, 8'h3A, 8'h31, 8'h31, 8'h3A, 8'h30, 8'h31, 8'h0D, 8'h0A};
    bit ok;
    // Entered right after report_done rose: a request now must be dropped.
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    tests++;
    if (rbusy_a !== 1'b0) begin fails++; $display("FAIL req_on_done: busy got %b expected 0", rbusy_a); end
    starts_a = 0;
    push_a(f);
    @(negedge clk); req_a = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rbusy_a !== 1'b1) begin fails++; $display("FAIL req_after_done: busy got %b expected 1", rbusy_a); end
    @(negedge clk); req_a = 1'b0;
    wait_done(1'b0, ok);
    tests++;
    if (starts_a != 10) begin fails++; $display("FAIL b2b_count: got %0d expected 10", starts_a); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] f[10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
    bit ok;
    busy_mode_a = 1'b1; starts_a = 0;
    hour = 5'd12; min = 6'd34; sec = 6'd56;
    push_a(f);
    pulse_req_a();
    for (int i = 0; i < 300 && starts_a < 4; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    tests += 4;
    if (start_a !== 1'b0) begin fails++; $display("FAIL mid_rst_start: got %b expected 0", start_a); end
    if (data_a !== 8'h00) begin fails++; $display("FAIL mid_rst_data: got %h expected 00", data_a); end
    if (rbusy_a !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b expected 0", rbusy_a); end
    if (done_a !== 1'b0)  begin fails++; $display("FAIL mid_rst_done: got %b expected 0", done_a); end
    exp_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    starts_a = 0;
    repeat (40) @(posedge clk);
    tests++;
    if (starts_a != 0) begin fails++; $display("FAIL post_rst_quiet: got %0d starts expected 0", starts_a); end
    push_a(f);
    pulse_req_a();
    wait_done(1'b0, ok);
    tests++;
    if (starts_a != 10) begin fails++; $display("FAIL post_rst_count: got %0d expected 10", starts_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_crlf();
    test_clamp();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
